// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM access controller.
// State encoding, default widths and RWS pin levels.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  localparam logic RWS_WRITE = 1'b1;
  localparam logic RWS_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_INIT
  } state_t;

  // Width of a phase counter able to hold the longest phase length.
  function automatic int cnt_w(int a, int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/ram_ctrl_timer.sv
// Loadable phase down-counter; done while the count is 1.
// Ports: clk, rst_n, load, load_val -> done. Never wraps below 1.
module ram_ctrl_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt > ONE) begin
      cnt <= cnt - ONE;
    end
  end

  assign done = (cnt == ONE);

endmodule

// File: rtl/ram_access_ctrl.sv
// Synchronous front-end for a CS/RWS-strobed async RAM: req/rsp
// handshake in, Ram* pins out. Macro RAM_ACCESS_CTRL_ZEROFILL_EN adds zero-fill init.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqData,
  output logic              RspValid,
  output logic [DATA_W-1:0] RspData,
  output logic              Busy,
  output logic              InitDone,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [DATA_W-1:0] RamDataIn,
  output logic              RamRWS,
  output logic              RamCS,
  input  logic [DATA_W-1:0] RamDataOut
);

  localparam int CNT_W = cnt_w(SETUP_CYC, STROBE_CYC);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC);

  state_t state;

  logic init_done;
  logic launch_init;
  logic xfer;
  logic tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic tmr_done;

`ifdef RAM_ACCESS_CTRL_ZEROFILL_EN
  // IDLE starts address 0 right after reset; INIT starts the rest.
  assign launch_init = (state == ST_INIT) |
                       ((state == ST_IDLE) & ~init_done);
`else
  assign init_done   = 1'b1;
  assign launch_init = 1'b0;
`endif

  assign InitDone = init_done;
  assign ReqReady = (state == ST_IDLE) & init_done;
  assign xfer     = ReqValid & ReqReady;
  assign Busy     = (state != ST_IDLE);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = SETUP_LD;
    if (xfer | launch_init) begin
      tmr_load = 1'b1;
      tmr_val  = SETUP_LD;
    end else if ((state == ST_SETUP) & tmr_done) begin
      tmr_load = 1'b1;
      tmr_val  = STROBE_LD;
    end
  end

  ram_ctrl_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ST_IDLE;
      RamCS     <= 1'b0;
      RamRWS    <= RWS_READ;
      RamAddr   <= '0;
      RamDataIn <= '0;
      RspValid  <= 1'b0;
      RspData   <= '0;
`ifdef RAM_ACCESS_CTRL_ZEROFILL_EN
      init_done <= 1'b0;
`endif
    end else begin
      RspValid <= 1'b0;
      unique case (state)
        ST_IDLE, ST_INIT: begin
          if (launch_init) begin
            // Address walks via RamAddr itself.
            RamRWS    <= RWS_WRITE;
            RamDataIn <= '0;
            state     <= ST_SETUP;
          end else if (xfer) begin
            RamAddr   <= ReqAddr;
            RamRWS    <= ReqWrite;
            RamDataIn <= ReqData;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            RamCS <= 1'b1;
            state <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (tmr_done) begin
            RamCS <= 1'b0;
            state <= ST_HOLD;
            if (RamRWS == RWS_READ) begin
              RspData  <= RamDataOut;
              RspValid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // No write strobe may be seen while parked.
          RamRWS <= RWS_READ;
          state  <= ST_IDLE;
`ifdef RAM_ACCESS_CTRL_ZEROFILL_EN
          if (!init_done) begin
            RamAddr <= RamAddr + ADDR_W'(1);
            if (&RamAddr) begin
              init_done <= 1'b1;
            end else begin
              state <= ST_INIT;
            end
          end
`endif
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed self-checking bench for ram_access_ctrl.
// Default-parameter DUT with a RAM model, plus a SETUP=3/STROBE=1 DUT.
module tb_ram_access_ctrl;

`ifdef RAM_ACCESS_CTRL_ZEROFILL_EN
  localparam int   INIT_LEN = 160;
  localparam logic INIT_RST = 1'b0;
`else
  localparam int   INIT_LEN = 0;
  localparam logic INIT_RST = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [4:0] req_addr;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       init_done;
  logic [4:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_rws;
  logic       ram_cs;
  wire  [7:0] ram_dout;

  logic       p_valid;
  logic       p_ready;
  logic       p_write;
  logic [4:0] p_addr;
  logic [7:0] p_data;
  logic       p_rsp_valid;
  logic [7:0] p_rsp_data;
  logic       p_busy;
  logic       p_init_done;
  logic [4:0] p_ram_addr;
  logic [7:0] p_ram_din;
  logic       p_rws;
  logic       p_cs;
  wire  [7:0] p_dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mem [32];
  logic [7:0] rsp_q [$];
  int cs_run = 0;
  int cs_len = 0;
  logic cs_prev = 1'b0;
  logic [4:0] addr_prev = '0;
  int addr_glitch = 0;

  always #5 clk = ~clk;

  ram_access_ctrl u_dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .ReqValid  (req_valid),
    .ReqReady  (req_ready),
    .ReqWrite  (req_write),
    .ReqAddr   (req_addr),
    .ReqData   (req_data),
    .RspValid  (rsp_valid),
    .RspData   (rsp_data),
    .Busy      (busy),
    .InitDone  (init_done),
    .RamAddr   (ram_addr),
    .RamDataIn (ram_din),
    .RamRWS    (ram_rws),
    .RamCS     (ram_cs),
    .RamDataOut(ram_dout)
  );

  ram_access_ctrl #(
    .SETUP_CYC (3),
    .STROBE_CYC(1)
  ) u_dut_p (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .ReqValid  (p_valid),
    .ReqReady  (p_ready),
    .ReqWrite  (p_write),
    .ReqAddr   (p_addr),
    .ReqData   (p_data),
    .RspValid  (p_rsp_valid),
    .RspData   (p_rsp_data),
    .Busy      (p_busy),
    .InitDone  (p_init_done),
    .RamAddr   (p_ram_addr),
    .RamDataIn (p_ram_din),
    .RamRWS    (p_rws),
    .RamCS     (p_cs),
    .RamDataOut(p_dout)
  );

  // Async RAM model: write while strobed, drive data on strobed read.
  always @(posedge clk)
    if (ram_cs && ram_rws) mem[ram_addr] <= ram_din;
  assign ram_dout = (ram_cs && !ram_rws) ? mem[ram_addr] : 'z;
  assign p_dout   = (p_cs && !p_rws) ? 8'h3C : 'z;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_cs) begin
      cs_run <= cs_run + 1;
      if (cs_prev && ram_addr != addr_prev)
        addr_glitch <= addr_glitch + 1;
    end else if (cs_run != 0) begin
      cs_len <= cs_run;
      cs_run <= 0;
    end
    cs_prev   <= ram_cs;
    addr_prev <= ram_addr;
    if (rsp_valid) rsp_q.push_back(rsp_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the caller on the negedge just after the accept edge.
  task automatic do_req(input logic w, input logic [4:0] a,
                        input logic [7:0] d);
    int k;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    k = 0;
    while (!req_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready_wait", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", 32'(busy), 0);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int k;
    int base;
    int acc [4];

    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    p_valid   = 1'b0;
    p_write   = 1'b0;
    p_addr    = '0;
    p_data    = '0;

    repeat (2) @(negedge clk);
    chk("rst_cs",       32'(ram_cs),    0);
    chk("rst_rws",      32'(ram_rws),   0);
    chk("rst_addr",     32'(ram_addr),  0);
    chk("rst_din",      32'(ram_din),   0);
    chk("rst_rspv",     32'(rsp_valid), 0);
    chk("rst_rspd",     32'(rsp_data),  0);
    chk("rst_busy",     32'(busy),      0);
    chk("rst_initdone", 32'(init_done), 32'(INIT_RST));
    chk("rst_ready",    32'(req_ready), 32'(INIT_RST));

    rst_n = 1'b1;
    wait_init(n);
    chk("init_len", n, INIT_LEN);
    chk("init_done", 32'(init_done), 1);

    // Write A5 @5.
    do_req(1'b1, 5'd5, 8'hA5);
    chk("wr_busy",  32'(busy),      1);
    chk("wr_ready", 32'(req_ready), 0);
    wait_idle();
    chk("wr_cs_len", cs_len, 2);
    chk("wr_mem5",   32'(mem[5]), 32'h A5);
    chk("wr_no_rsp", rsp_q.size(), 0);
    chk("idle_rws",  32'(ram_rws), 0);

    // Read @5.
    do_req(1'b0, 5'd5, 8'h00);
    wait_rsp(n);
    chk("rd_latency", n, 3);
    chk("rd_data",    32'(rsp_data), 32'h A5);
    @(negedge clk);
    chk("rd_pulse",   32'(rsp_valid), 0);
    wait_idle();
    chk("rd_cs_len",  cs_len, 2);

    // Boundary addresses.
    do_req(1'b1, 5'd0, 8'h3C);
    wait_idle();
    do_req(1'b1, 5'd31, 8'hC3);
    wait_idle();
    do_req(1'b0, 5'd0, 8'h00);
    wait_rsp(n);
    chk("rd0_data",  32'(rsp_data), 32'h3C);
    wait_idle();
    do_req(1'b0, 5'd31, 8'h00);
    wait_rsp(n);
    chk("rd31_data", 32'(rsp_data), 32'h C3);
    wait_idle();

    // Back-to-back reads with ReqValid held.
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 5'(10 + i), 8'(8'h11 * (i + 1)));
      wait_idle();
    end
    base = rsp_q.size();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 5'd10;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (!req_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("b2b_ready_wait", 32'(req_ready), 1);
      @(posedge clk);
      #1 acc[i] = cyc;
      @(negedge clk);
      req_addr = 5'(10 + i + 1);
    end
    req_valid = 1'b0;
    chk("b2b_gap1", acc[1] - acc[0], 5);
    chk("b2b_gap2", acc[2] - acc[1], 5);
    chk("b2b_gap3", acc[3] - acc[2], 5);
    wait_rsp(n);
    @(negedge clk);
    wait_idle();
    @(negedge clk);
    chk("b2b_count", rsp_q.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (rsp_q.size() > base + i)
        chk("b2b_data", 32'(rsp_q[base + i]), 32'(8'h11 * (i + 1)));
    end

    // Reset in the middle of a write strobe.
    base = rsp_q.size();
    do_req(1'b1, 5'd20, 8'h5A);
    k = 0;
    while (!ram_cs && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("mid_cs_high", 32'(ram_cs), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cs",   32'(ram_cs),    0);
    chk("mid_rst_busy", 32'(busy),      0);
    chk("mid_rst_rws",  32'(ram_rws),   0);
    chk("mid_rst_addr", 32'(ram_addr),  0);
    chk("mid_rst_rspv", 32'(rsp_valid), 0);
    chk("mid_rst_rspd", 32'(rsp_data),  0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n);
    chk("reinit_len", n, INIT_LEN);
    repeat (4) @(negedge clk);
    chk("mid_no_rsp", rsp_q.size() - base, 0);

`ifdef RAM_ACCESS_CTRL_ZEROFILL_EN
    do_req(1'b0, 5'd17, 8'h00);
    wait_rsp(n);
    chk("zf_rd17", 32'(rsp_data), 32'h00);
`else
    do_req(1'b0, 5'd31, 8'h00);
    wait_rsp(n);
    chk("keep_rd31", 32'(rsp_data), 32'h C3);
`endif
    wait_idle();
    chk("addr_stable", addr_glitch, 0);

    // SETUP_CYC=3, STROBE_CYC=1 instance.
    k = 0;
    while (!p_init_done && k < 500) begin
      @(negedge clk);
      k++;
    end
    p_valid = 1'b1;
    p_write = 1'b0;
    p_addr  = 5'd7;
    k = 0;
    while (!p_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("p_ready_wait", 32'(p_ready), 1);
    @(negedge clk);
    p_valid = 1'b0;
    n = 0;
    while (!p_cs && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("p_cs_delay", n, 3);
    @(negedge clk);
    n++;
    chk("p_cs_len1", 32'(p_cs), 0);
    chk("p_latency", n, 4);
    chk("p_rspv",    32'(p_rsp_valid), 1);
    chk("p_rspd",    32'(p_rsp_data), 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
